// File: rtl/nogtx_word_aligner_if.sv
// Signal bundle between the bit latch / control plane and the word aligner.
// master drives the serial bit and controls, slave is the aligner itself.
interface nogtx_word_aligner_if #(
    parameter int WORD_BITS = 8
);
    localparam int SW = $clog2(WORD_BITS);

    logic                 enable;
    logic                 polarity;
    logic                 msb_first;
    logic                 auto_mode;
    logic                 bitslip;
    logic                 din;
    logic [WORD_BITS-1:0] dout;
    logic                 dout_valid;
    logic                 locked;
    logic                 align_error;
    logic [SW-1:0]        slip_offset;
    logic [7:0]           lock_loss_cnt;

    modport master (
        output enable, polarity, msb_first, auto_mode, bitslip, din,
        input  dout, dout_valid, locked, align_error, slip_offset, lock_loss_cnt
    );

    modport slave (
        input  enable, polarity, msb_first, auto_mode, bitslip, din,
        output dout, dout_valid, locked, align_error, slip_offset, lock_loss_cnt
    );
endinterface

// File: rtl/nogtx_word_aligner.sv
// Serial-to-word deserialiser with bit-slip word alignment and lock tracking.
// A slip cycle holds the phase counter, pushing every later boundary one bit later.
module nogtx_word_aligner #(
    parameter int                   WORD_BITS    = 8,
    parameter logic [WORD_BITS-1:0] SYNC_WORD    = 'h3C,
    parameter int                   LOCK_COUNT   = 4,
    parameter int                   SYNC_WINDOW  = 16,
    parameter int                   SEARCH_LIMIT = 32
) (
    input  logic                  clk320,
    input  logic                  rst,
    nogtx_word_aligner_if.slave   bus
);
    localparam int SW = $clog2(WORD_BITS);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    state_t               r_state;
    logic [WORD_BITS-1:0] r_sr;
    logic [SW-1:0]        r_phase;
    logic                 r_slip_pend;
    logic [3:0]           r_match_cnt;
    logic [7:0]           r_miss_cnt;
    logic [15:0]          r_search_cnt;
    logic [WORD_BITS-1:0] r_dout;
    logic                 r_dout_valid;
    logic                 r_locked;
    logic                 r_align_error;
    logic [SW-1:0]        r_slip_offset;
    logic [7:0]           r_lock_loss_cnt;

    logic                 w_bit;
    logic [WORD_BITS-1:0] w_sr_next;
    logic                 w_boundary;
    logic                 w_match;
    logic                 w_manual_req;

    assign w_bit        = bus.din ^ bus.polarity;
    assign w_boundary   = (r_phase == SW'(WORD_BITS - 1)) && !r_slip_pend;
    assign w_match      = (w_sr_next == SYNC_WORD);
    assign w_manual_req = bus.bitslip && !bus.auto_mode;

    always_comb begin
        w_sr_next = r_sr;
        if (bus.msb_first)
            w_sr_next = {r_sr[WORD_BITS-2:0], w_bit};
        else
            w_sr_next = {w_bit, r_sr[WORD_BITS-1:1]};
    end

    always_ff @(posedge clk320) begin
        if (rst || !bus.enable) begin
            r_state       <= ST_SEARCH;
            r_sr          <= '0;
            r_phase       <= '0;
            r_slip_pend   <= 1'b0;
            r_match_cnt   <= '0;
            r_miss_cnt    <= '0;
            r_search_cnt  <= '0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_locked      <= 1'b0;
            r_align_error <= 1'b0;
            r_slip_offset <= '0;
            if (rst)
                r_lock_loss_cnt <= '0;
        end else begin
            r_sr         <= w_sr_next;
            r_dout_valid <= 1'b0;

            if (r_slip_pend) begin
                r_slip_pend   <= 1'b0;
                r_slip_offset <= (r_slip_offset == SW'(WORD_BITS - 1)) ? '0 : r_slip_offset + 1'b1;
                // Only a manual slip can land while locked; it invalidates the boundary.
                if (r_state == ST_LOCKED) begin
                    r_state      <= ST_SEARCH;
                    r_locked     <= 1'b0;
                    r_miss_cnt   <= '0;
                    r_search_cnt <= '0;
                    if (r_lock_loss_cnt != 8'hFF)
                        r_lock_loss_cnt <= r_lock_loss_cnt + 1'b1;
                end
            end else begin
                r_phase <= (r_phase == SW'(WORD_BITS - 1)) ? '0 : r_phase + 1'b1;
            end

            if (w_manual_req && !r_slip_pend)
                r_slip_pend <= 1'b1;

            if (w_boundary) begin
                r_dout       <= w_sr_next;
                r_dout_valid <= 1'b1;
                case (r_state)
                    ST_SEARCH: begin
                        if (w_match) begin
                            if (LOCK_COUNT == 1) begin
                                r_state    <= ST_LOCKED;
                                r_locked   <= 1'b1;
                                r_miss_cnt <= '0;
                            end else begin
                                r_state     <= ST_VERIFY;
                                r_match_cnt <= 4'd1;
                            end
                        end else begin
                            if (bus.auto_mode)
                                r_slip_pend <= 1'b1;
                            if (r_search_cnt < 16'(SEARCH_LIMIT))
                                r_search_cnt <= r_search_cnt + 1'b1;
                            if (r_search_cnt >= 16'(SEARCH_LIMIT - 1))
                                r_align_error <= 1'b1;
                        end
                    end
                    ST_VERIFY: begin
                        if (w_match) begin
                            if (r_match_cnt == 4'(LOCK_COUNT - 1)) begin
                                r_state    <= ST_LOCKED;
                                r_locked   <= 1'b1;
                                r_miss_cnt <= '0;
                            end else begin
                                r_match_cnt <= r_match_cnt + 1'b1;
                            end
                        end else begin
                            r_state     <= ST_SEARCH;
                            r_match_cnt <= '0;
                            if (bus.auto_mode)
                                r_slip_pend <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_match) begin
                            r_miss_cnt <= '0;
                        end else if (r_miss_cnt == 8'(SYNC_WINDOW - 1)) begin
                            r_state      <= ST_SEARCH;
                            r_locked     <= 1'b0;
                            r_miss_cnt   <= '0;
                            r_match_cnt  <= '0;
                            r_search_cnt <= '0;
                            if (r_lock_loss_cnt != 8'hFF)
                                r_lock_loss_cnt <= r_lock_loss_cnt + 1'b1;
                        end else begin
                            r_miss_cnt <= r_miss_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_SEARCH;
                endcase
            end
        end
    end

    assign bus.dout          = r_dout;
    assign bus.dout_valid    = r_dout_valid;
    assign bus.locked        = r_locked;
    assign bus.align_error   = r_align_error;
    assign bus.slip_offset   = r_slip_offset;
    assign bus.lock_loss_cnt = r_lock_loss_cnt;
endmodule

// File: tb/tb_nogtx_word_aligner.sv
// Directed bench for nogtx_word_aligner (W=8, sync 0x3C, lock 4, window 16, limit 32).
module tb_nogtx_word_aligner;
    logic clk320 = 1'b0;
    logic rst    = 1'b1;
    always #5 clk320 = ~clk320;

    nogtx_word_aligner_if #(.WORD_BITS(8)) bus ();

    nogtx_word_aligner #(
        .WORD_BITS(8), .SYNC_WORD(8'h3C), .LOCK_COUNT(4),
        .SYNC_WINDOW(16), .SEARCH_LIMIT(32)
    ) dut (
        .clk320(clk320),
        .rst(rst),
        .bus(bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          last_vcyc = -100;
    int          n_valid = 0;
    int          n_gap9  = 0;
    int unsigned g_k   = 0;
    logic        g_inv = 1'b0;
    logic        g_msb = 1'b0;

    // One clock: drive din, wait past the edge, record strobes and boundary gaps.
    task automatic tick(input logic b);
        bus.din = b;
        @(posedge clk320);
        #1;
        bus.bitslip = 1'b0;
        if (bus.dout_valid === 1'b1) begin
            n_valid++;
            if (cyc - last_vcyc == 9) n_gap9++;
            last_vcyc = cyc;
        end
        cyc++;
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            tick((g_msb ? w[7 - g_k] : w[g_k]) ^ g_inv);
            g_k = (g_k + 1) % 8;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
        g_k = 0;
        n_valid = 0;
        n_gap9 = 0;
        last_vcyc = -100;
    endtask

    task automatic test_reset();
        reset_dut();
        if (bus.dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %0h want 0", bus.dout); end total++;
        if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", bus.dout_valid); end total++;
        if (bus.locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %0b want 0", bus.locked); end total++;
        if (bus.align_error !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", bus.align_error); end total++;
        if (bus.slip_offset !== 3'd0) begin bad++; $display("FAIL reset_slip: got %0d want 0", bus.slip_offset); end total++;
        if (bus.lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL reset_loss: got %0d want 0", bus.lock_loss_cnt); end total++;
    endtask

    task automatic test_aligned();
        bus.auto_mode = 1'b1;
        reset_dut();
        send_bits(8'h3C, 24);
        if (bus.locked !== 1'b0) begin bad++; $display("FAIL aligned_locked3: got %0b want 0", bus.locked); end total++;
        if (n_valid != 3) begin bad++; $display("FAIL aligned_nvalid3: got %0d want 3", n_valid); end total++;
        send_bits(8'h3C, 8);
        if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL aligned_valid: got %0b want 1", bus.dout_valid); end total++;
        if (bus.dout !== 8'h3C) begin bad++; $display("FAIL aligned_dout: got %0h want 3c", bus.dout); end total++;
        if (bus.locked !== 1'b1) begin bad++; $display("FAIL aligned_locked4: got %0b want 1", bus.locked); end total++;
        if (bus.slip_offset !== 3'd0) begin bad++; $display("FAIL aligned_slip: got %0d want 0", bus.slip_offset); end total++;
        send_bits(8'h3C, 1);
        if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL aligned_strobe_len: got %0b want 0", bus.dout_valid); end total++;
        if (n_gap9 != 0) begin bad++; $display("FAIL aligned_gap9: got %0d want 0", n_gap9); end total++;
    endtask

    task automatic test_misalign_auto();
        bus.auto_mode = 1'b1;
        reset_dut();
        repeat (3) tick(1'b0);
        send_bits(8'h3C, 48);
        send_bits(8'h3C, 7);
        if (bus.locked !== 1'b0) begin bad++; $display("FAIL mis_locked_early: got %0b want 0", bus.locked); end total++;
        if (bus.slip_offset !== 3'd3) begin bad++; $display("FAIL mis_slip: got %0d want 3", bus.slip_offset); end total++;
        send_bits(8'h3C, 1);
        if (bus.locked !== 1'b1) begin bad++; $display("FAIL mis_locked: got %0b want 1", bus.locked); end total++;
        if (bus.dout !== 8'h3C) begin bad++; $display("FAIL mis_dout: got %0h want 3c", bus.dout); end total++;
        if (n_valid != 7) begin bad++; $display("FAIL mis_nvalid: got %0d want 7", n_valid); end total++;
        if (n_gap9 != 3) begin bad++; $display("FAIL mis_gap9: got %0d want 3", n_gap9); end total++;
        send_bits(8'h3C, 16);
        if (bus.slip_offset !== 3'd3) begin bad++; $display("FAIL mis_slip_hold: got %0d want 3", bus.slip_offset); end total++;
    endtask

    task automatic test_polarity_order();
        bus.auto_mode = 1'b1;
        bus.polarity = 1'b1;
        g_inv = 1'b1;
        reset_dut();
        send_bits(8'h3C, 32);
        if (bus.dout !== 8'h3C) begin bad++; $display("FAIL pol_dout: got %0h want 3c", bus.dout); end total++;
        if (bus.locked !== 1'b1) begin bad++; $display("FAIL pol_locked: got %0b want 1", bus.locked); end total++;
        if (bus.slip_offset !== 3'd0) begin bad++; $display("FAIL pol_slip: got %0d want 0", bus.slip_offset); end total++;
        bus.polarity = 1'b0;
        g_inv = 1'b0;
        bus.msb_first = 1'b1;
        g_msb = 1'b1;
        reset_dut();
        send_bits(8'h3C, 32);
        if (bus.dout !== 8'h3C) begin bad++; $display("FAIL msb_dout: got %0h want 3c", bus.dout); end total++;
        if (bus.locked !== 1'b1) begin bad++; $display("FAIL msb_locked: got %0b want 1", bus.locked); end total++;
        if (n_valid != 4) begin bad++; $display("FAIL msb_nvalid: got %0d want 4", n_valid); end total++;
        bus.msb_first = 1'b0;
        g_msb = 1'b0;
    endtask

    task automatic test_lock_loss();
        bus.auto_mode = 1'b1;
        reset_dut();
        send_bits(8'h3C, 32);
        send_bits(8'h00, 15 * 8);
        if (bus.locked !== 1'b1) begin bad++; $display("FAIL loss_locked15: got %0b want 1", bus.locked); end total++;
        if (bus.lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL loss_cnt15: got %0d want 0", bus.lock_loss_cnt); end total++;
        send_bits(8'h00, 8);
        if (bus.locked !== 1'b0) begin bad++; $display("FAIL loss_locked16: got %0b want 0", bus.locked); end total++;
        if (bus.lock_loss_cnt !== 8'd1) begin bad++; $display("FAIL loss_cnt16: got %0d want 1", bus.lock_loss_cnt); end total++;
        send_bits(8'h3C, 24);
        if (bus.locked !== 1'b0) begin bad++; $display("FAIL relock_early: got %0b want 0", bus.locked); end total++;
        send_bits(8'h3C, 8);
        if (bus.locked !== 1'b1) begin bad++; $display("FAIL relock: got %0b want 1", bus.locked); end total++;
        if (bus.slip_offset !== 3'd0) begin bad++; $display("FAIL relock_slip: got %0d want 0", bus.slip_offset); end total++;
        bus.enable = 1'b0;
        tick(1'b0);
        if (bus.locked !== 1'b0) begin bad++; $display("FAIL disable_locked: got %0b want 0", bus.locked); end total++;
        if (bus.dout !== 8'h00) begin bad++; $display("FAIL disable_dout: got %0h want 0", bus.dout); end total++;
        if (bus.lock_loss_cnt !== 8'd1) begin bad++; $display("FAIL disable_loss_kept: got %0d want 1", bus.lock_loss_cnt); end total++;
        bus.enable = 1'b1;
    endtask

    task automatic test_search_limit();
        bus.auto_mode = 1'b1;
        reset_dut();
        repeat (286) tick(1'b0);
        if (bus.align_error !== 1'b0) begin bad++; $display("FAIL limit_err_early: got %0b want 0", bus.align_error); end total++;
        tick(1'b0);
        if (bus.align_error !== 1'b1) begin bad++; $display("FAIL limit_err: got %0b want 1", bus.align_error); end total++;
        if (bus.slip_offset !== 3'd7) begin bad++; $display("FAIL limit_slip31: got %0d want 7", bus.slip_offset); end total++;
        tick(1'b0);
        if (bus.slip_offset !== 3'd0) begin bad++; $display("FAIL limit_slip32: got %0d want 0", bus.slip_offset); end total++;
        repeat (20) tick(1'b0);
        if (bus.align_error !== 1'b1) begin bad++; $display("FAIL limit_sticky: got %0b want 1", bus.align_error); end total++;
        bus.enable = 1'b0;
        tick(1'b0);
        bus.enable = 1'b1;
        if (bus.align_error !== 1'b0) begin bad++; $display("FAIL limit_clear: got %0b want 0", bus.align_error); end total++;
    endtask

    task automatic test_manual_mode();
        bus.auto_mode = 1'b0;
        reset_dut();
        repeat (3) tick(1'b0);
        send_bits(8'h3C, 48);
        if (bus.slip_offset !== 3'd0) begin bad++; $display("FAIL man_noslip: got %0d want 0", bus.slip_offset); end total++;
        if (bus.locked !== 1'b0) begin bad++; $display("FAIL man_nolock: got %0b want 0", bus.locked); end total++;
        if (n_valid != 6) begin bad++; $display("FAIL man_nvalid: got %0d want 6", n_valid); end total++;
        repeat (3) begin
            bus.bitslip = 1'b1;
            send_bits(8'h3C, 3);
        end
        send_bits(8'h3C, 64);
        if (bus.slip_offset !== 3'd3) begin bad++; $display("FAIL man_slip3: got %0d want 3", bus.slip_offset); end total++;
        if (bus.locked !== 1'b1) begin bad++; $display("FAIL man_locked: got %0b want 1", bus.locked); end total++;
        bus.bitslip = 1'b1;
        send_bits(8'h3C, 2);
        if (bus.locked !== 1'b0) begin bad++; $display("FAIL man_slip_unlock: got %0b want 0", bus.locked); end total++;
        if (bus.lock_loss_cnt !== 8'd1) begin bad++; $display("FAIL man_slip_loss: got %0d want 1", bus.lock_loss_cnt); end total++;
        if (bus.slip_offset !== 3'd4) begin bad++; $display("FAIL man_slip4: got %0d want 4", bus.slip_offset); end total++;
        send_bits(8'h3C, 3);
        rst = 1'b1;
        tick(1'b0);
        if (bus.dout !== 8'h00) begin bad++; $display("FAIL midrst_dout: got %0h want 0", bus.dout); end total++;
        if (bus.locked !== 1'b0) begin bad++; $display("FAIL midrst_locked: got %0b want 0", bus.locked); end total++;
        if (bus.slip_offset !== 3'd0) begin bad++; $display("FAIL midrst_slip: got %0d want 0", bus.slip_offset); end total++;
        if (bus.lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL midrst_loss: got %0d want 0", bus.lock_loss_cnt); end total++;
        rst = 1'b0;
    endtask

    initial begin
        bus.enable    = 1'b1;
        bus.polarity  = 1'b0;
        bus.msb_first = 1'b0;
        bus.auto_mode = 1'b1;
        bus.bitslip   = 1'b0;
        bus.din       = 1'b0;
        test_reset();
        test_aligned();
        test_misalign_auto();
        test_polarity_order();
        test_lock_loss();
        test_search_limit();
        test_manual_mode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
